// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and defaults for the CPU clock-step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV         = 25000000;
    localparam int DEF_CNT_W           = 25;
    localparam int DEF_STEP_CNT_W      = 16;

    // True when a cnt_w-bit counter can reach max(db, div) - 1.
    function automatic bit cnt_w_ok(input int cnt_w, input int db, input int div);
        longint need;
        need = longint'((db > div) ? db : div) - longint'(1);
        return need < (longint'(1) << cnt_w);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Button/switch/halt inputs and step/status outputs of the step controller.
interface cpu_step_ctrl_if
    import step_ctrl_pkg::*;
#(
    parameter int STEP_CNT_W = DEF_STEP_CNT_W
) ();
    logic                  step_btn;
    logic                  run_sw;
    logic                  halt;
    logic                  step_en;
    logic [STEP_CNT_W-1:0] step_count;
    logic                  running;
    logic                  halted;

    modport master (
        output step_btn, run_sw, halt,
        input  step_en, step_count, running, halted
    );

    modport slave (
        input  step_btn, run_sw, halt,
        output step_en, step_count, running, halted
    );
endinterface

// File: rtl/cpu_step_ctrl_debounce.sv
// Step button conditioning: 2-flop synchronizer, stability debounce and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d, level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample matching the current level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync2_q;
            else                   cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;
endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle core: manual steps, free-run
// divider and halt latch. Optional hold-to-repeat stepping via AUTO_REPEAT_EN.
module cpu_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int STEP_CNT_W      = DEF_STEP_CNT_W
) (
    input  logic           clk_fpga,
    input  logic           reset,
    cpu_step_ctrl_if.slave bus
);
    localparam bit               CNT_W_OK = cnt_w_ok(CNT_W, DEBOUNCE_CYCLES, RUN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

    state_e                state_q, state_d;
    logic                  run_s1_q, run_s2_q;
    logic [CNT_W-1:0]      div_q, div_d;
    logic                  step_en_q, step_en_d;
    logic                  running_q, running_d;
    logic                  halted_q, halted_d;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic                  btn_level, step_req, rep_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clk_i  (clk_fpga),
        .rst_i  (reset),
        .btn_i  (bus.step_btn),
        .level_o(btn_level),
        .rise_o (step_req)
    );

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;

    // Repeat timer restarts on the initial press pulse and on release.
    always_comb begin
        rep_d     = '0;
        rep_pulse = 1'b0;
        if (state_q == IDLE && state_d == IDLE && btn_level && !step_req) begin
            if (rep_q == DIV_LAST) rep_pulse = 1'b1;
            else                   rep_d     = rep_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    logic unused_btn_level;
    assign unused_btn_level = btn_level;
    assign rep_pulse        = 1'b0;
`endif

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q      <= IDLE;
            run_s1_q     <= 1'b0;
            run_s2_q     <= 1'b0;
            div_q        <= '0;
            step_en_q    <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            assert (CNT_W_OK);
            state_q      <= state_d;
            run_s1_q     <= bus.run_sw;
            run_s2_q     <= run_s1_q;
            div_q        <= div_d;
            step_en_q    <= step_en_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_q + STEP_CNT_W'(step_en_q);
        end
    end

    // Halt outranks a switch change; HALTED is left only through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.halt) state_d = HALTED;
                     else if (run_s2_q) state_d = RUN;
            RUN:     if (bus.halt) state_d = HALTED;
                     else if (!run_s2_q) state_d = IDLE;
            default: state_d = HALTED;
        endcase
    end

    // Pulses only fire when the state holds, so halt or a mode change wins.
    always_comb begin
        div_d     = '0;
        step_en_d = 1'b0;
        if (state_q == RUN && state_d == RUN) begin
            if (div_q == DIV_LAST) step_en_d = 1'b1;
            else                   div_d     = div_q + CNT_W'(1);
        end else if (state_q == IDLE && state_d == IDLE) begin
            step_en_d = step_req | rep_pulse;
        end
        running_d = (state_d == RUN);
        halted_d  = (state_d == HALTED);
    end

    assign bus.step_en    = step_en_q;
    assign bus.step_count = step_count_q;
    assign bus.running    = running_q;
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: cycle vector table, latency sequence, random run.
module tb_cpu_step_ctrl;
    localparam int DB  = 4;
    localparam int DIV = 5;
    localparam int SCW = 4;
    localparam int M   = 1 << SCW;

    logic clk_fpga = 1'b0;
    logic reset;
    always #5 clk_fpga = ~clk_fpga;

    cpu_step_ctrl_if #(.STEP_CNT_W(SCW)) bus ();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (DIV),
        .CNT_W          (8),
        .STEP_CNT_W     (SCW)
    ) dut (
        .clk_fpga(clk_fpga),
        .reset   (reset),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [SCW+2:0] act, input logic [SCW+2:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {en,cnt,run,halt}=%h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: timing expressed as sample delays and run lengths.
    bit m_b1, m_b2, m_r1, m_r2, m_lvl, m_rose, m_en;
    int m_same_len, m_phase, m_mode, m_cnt;
    bit sb, sr, req, pulse;

    always @(posedge clk_fpga) begin
        if (reset) begin
            {m_b1, m_b2, m_r1, m_r2, m_lvl, m_rose, m_en} = '0;
            m_same_len = 0; m_phase = 0; m_mode = 0; m_cnt = 0;
        end else begin
            sb = m_b2; sr = m_r2;
            m_b2 = m_b1; m_b1 = bus.step_btn;
            m_r2 = m_r1; m_r1 = bus.run_sw;
            req = m_rose; m_rose = 1'b0;
            if (sb != m_lvl) begin
                m_same_len++;
                if (m_same_len == DB) begin m_lvl = sb; m_same_len = 0; m_rose = sb; end
            end else m_same_len = 0;
            m_cnt = (m_cnt + int'(m_en)) % M;
            pulse = 1'b0;
            if (m_mode == 2) pulse = 1'b0;
            else if (bus.halt) m_mode = 2;
            else if (m_mode == 0) begin
                if (sr) begin m_mode = 1; m_phase = 0; end
                else if (req) pulse = 1'b1;
            end else begin
                if (!sr) m_mode = 0;
                else begin
                    m_phase++;
                    if (m_phase == DIV) begin pulse = 1'b1; m_phase = 0; end
                end
            end
            m_en = pulse;
        end
    end

    typedef struct {
        string          tag;
        bit             rst, btn, run, hlt;
        bit             en;
        bit [SCW-1:0]   cnt;
        bit             running, halted;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(string tag, bit r, bit b, bit s, bit h,
                                bit en, int cnt, bit rn, bit hl);
        vec_t v;
        v.tag = tag; v.rst = r; v.btn = b; v.run = s; v.hlt = h;
        v.en = en; v.cnt = SCW'(cnt % M); v.running = rn; v.halted = hl;
        vecs.push_back(v);
    endfunction

    task automatic drive(bit r, bit b, bit s, bit h);
        reset = r; bus.step_btn = b; bus.run_sw = s; bus.halt = h;
        @(posedge clk_fpga);
        @(negedge clk_fpga);
    endtask

    function automatic logic [SCW+2:0] outs();
        return {bus.step_en, bus.step_count, bus.running, bus.halted};
    endfunction

    initial begin
        int  c;
        bit  en;
        int  lat;
        bit  seen;
        reset = 1'b1; bus.step_btn = 1'b0; bus.run_sw = 1'b0; bus.halt = 1'b0;

        // Row i is sampled at edge i of its block; expectations are post-edge.
        c = 0;
        for (int i = 0; i < 2; i++) add("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add("idle",  0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            en = (i == 6);
            add("manual", 0, i < 10, 0, 0, en, c, 0, 0); c += int'(en);
        end
        for (int i = 0; i < 11; i++) add("glitch", 0, i < 3, 0, 0, 0, c, 0, 0);
        for (int j = 0; j < 36; j++) begin
            en = (j >= 7 && j <= 31 && (j - 7) % DIV == 0);
            add("run", 0, 0, j < 30, 0, en, c, j >= 2 && j <= 31, 0); c += int'(en);
        end
        for (int k = 0; k < 40; k++)
            add("halt", 0, k >= 15 && k < 25, (k < 15) || (k >= 21 && k < 25), k == 7,
                0, c, k >= 2 && k < 7, k >= 7);
        c = 0;
        for (int k = 0; k < 26; k++) begin
            en = (k == 12);
            add("rst_mid", k == 0 || k == 5, (k >= 1 && k < 5) || (k >= 6 && k < 16),
                k >= 1 && k < 5, 0, en, c, k >= 3 && k < 5, 0);
            c += int'(en);
        end
        add("wrap_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        c = 0;
        for (int j = 0; j < 96; j++) begin
            en = (j >= 7 && j <= 91 && (j - 7) % DIV == 0);
            add("wrap", 0, 0, j < 90, 0, en, c, j >= 2 && j <= 91, 0); c += int'(en);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].btn, vecs[i].run, vecs[i].hlt);
            check(vecs[i].tag, outs(),
                  {vecs[i].en, vecs[i].cnt, vecs[i].running, vecs[i].halted});
        end
        check("wrap_final", outs(), {1'b0, SCW'(17 % M), 1'b0, 1'b0});

        // Press-to-pulse latency with a bounded wait.
        drive(1, 0, 0, 0);
        check("lat_reset", outs(), '0);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            drive(0, 1, 0, 0);
            lat++;
            seen = bus.step_en;
        end
        n_chk++;
        if (seen && lat == 7) n_pass++;
        else $display("FAIL latency: got %0d cycles (seen=%0b) expected 7", lat, seen);
        drive(0, 1, 0, 0);
        check("single_pulse", outs(), {1'b0, SCW'(1), 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0)  bus.step_btn = ~bus.step_btn;
            if ($urandom_range(0, 39) == 0) bus.run_sw   = ~bus.run_sw;
            bus.halt = ($urandom_range(0, 299) == 0);
            @(posedge clk_fpga);
            @(negedge clk_fpga);
            check("random", outs(), {m_en, SCW'(m_cnt), m_mode == 1, m_mode == 2});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
